// File: rtl/wb_write_port.sv
// Register-file write port: merges in-order ALU results and returning loads into one write.
// Loads wait in a small FIFO; ALU writes squash older queued loads to the same register.
module wb_write_port #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [AW-1:0]              alu_dest,
  input  logic [DW-1:0]              alu_result,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [AW-1:0]              mem_dest,
  input  logic [DW-1:0]              mem_data,
  output logic                       wb_en,
  output logic [AW-1:0]              wb_dest,
  output logic [DW-1:0]              wb_data,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       bad_dest
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = $clog2(STARVE_MAX+1);
  localparam logic [AW-1:0] BadDest = {AW{1'b1}};

  logic [AW-1:0] fifo_dest_q [DEPTH];
  logic [DW-1:0] fifo_data_q [DEPTH];
  logic          fifo_sq_q   [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          empty, head_sq, head_valid;
  logic          alu_acc, mem_acc, alu_bad, mem_bad, alu_wr;
  logic          pop, push, bypass, wr_en;
  logic [AW-1:0] wr_dest;
  logic [DW-1:0] wr_data;

  always_comb begin
    empty      = (count_q == '0);
    head_sq    = !empty && fifo_sq_q[rd_ptr_q];
    head_valid = !empty && !fifo_sq_q[rd_ptr_q];
    alu_ready  = !(head_valid && (starve_q == SW'(STARVE_MAX)));
    mem_ready  = (count_q < CW'(DEPTH));
    alu_acc    = alu_valid && alu_ready;
    mem_acc    = mem_valid && mem_ready;
    alu_bad    = alu_acc && (alu_dest == BadDest);
    mem_bad    = mem_acc && (mem_dest == BadDest);
    alu_wr     = alu_acc && !alu_bad;
  end

  // A granted ALU item owns the port even when it is dropped for a bad dest.
  always_comb begin
    pop      = head_sq;
    bypass   = 1'b0;
    wr_en    = 1'b0;
    wr_dest  = alu_dest;
    wr_data  = alu_result;
    starve_d = starve_q;
    if (alu_acc) begin
      wr_en = !alu_bad;
      if (head_valid) starve_d = starve_q + SW'(1);
    end else if (head_valid) begin
      wr_en    = 1'b1;
      wr_dest  = fifo_dest_q[rd_ptr_q];
      wr_data  = fifo_data_q[rd_ptr_q];
      pop      = 1'b1;
      starve_d = '0;
    end else if (empty && mem_acc) begin
      bypass  = 1'b1;
      wr_en   = !mem_bad;
      wr_dest = mem_dest;
      wr_data = mem_data;
    end
    if (empty) starve_d = '0;
    push    = mem_acc && !mem_bad && !bypass;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_dest_q[i] <= '0;
        fifo_data_q[i] <= '0;
        fifo_sq_q[i]   <= 1'b0;
      end
    end else begin
      count_q  <= count_d;
      starve_q <= starve_d;
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alu_wr && (fifo_dest_q[i] == alu_dest)) fifo_sq_q[i] <= 1'b1;
        // A load accepted alongside an ALU write to the same reg is older, so it lands squashed.
        if (push && (wr_ptr_q == PW'(i))) begin
          fifo_dest_q[i] <= mem_dest;
          fifo_data_q[i] <= mem_data;
          fifo_sq_q[i]   <= alu_wr && (alu_dest == mem_dest);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en    <= 1'b0;
      wb_dest  <= '0;
      wb_data  <= '0;
      bad_dest <= 1'b0;
    end else begin
      wb_en    <= wr_en;
      bad_dest <= alu_bad || mem_bad;
      if (wr_en) begin
        wb_dest <= wr_dest;
        wb_data <= wr_data;
      end
    end
  end

  assign q_count = count_q;

endmodule

// File: tb/tb_wb_write_port.sv
// Bench for wb_write_port: expected writes are queued as stimulus is driven and
// matched in order against wb_* on every write cycle.
module tb_wb_write_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [3:0]  alu_dest, mem_dest, wb_dest;
  logic [31:0] alu_result, mem_data, wb_data;
  logic        wb_en, bad_dest;
  logic [2:0]  q_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [35:0] exp_q [$];

  wb_write_port dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_dest  (alu_dest),
    .alu_result(alu_result),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_dest  (mem_dest),
    .mem_data  (mem_data),
    .wb_en     (wb_en),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data),
    .q_count   (q_count),
    .bad_dest  (bad_dest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_wb(input logic [3:0] d, input logic [31:0] v);
    exp_q.push_back({d, v});
  endtask

  // Present inputs for one cycle; returns 1 time unit after the edge.
  task automatic cyc(input logic av, input logic [3:0] ad, input logic [31:0] adat,
                     input logic mv, input logic [3:0] md, input logic [31:0] mdat);
    alu_valid = av; alu_dest = ad; alu_result = adat;
    mem_valid = mv; mem_dest = md; mem_data = mdat;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (wb_en) begin
      if (exp_q.size() == 0) check("wb_unexpected", wb_en, 1'b0);
      else check("wb_write", {wb_dest, wb_data}, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_dest = '0; alu_result = '0;
    mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_en", wb_en, 1'b0);
    check("rst_wb_dest", wb_dest, 4'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_q_count", q_count, 3'd0);
    check("rst_bad_dest", bad_dest, 1'b0);
    check("rst_mem_ready", mem_ready, 1'b1);
    rst = 1'b0;
    idle(1);

    // ALU only
    expect_wb(4'd3, 32'h1234);
    cyc(1'b1, 4'd3, 32'h1234, 1'b0, 4'h0, 32'h0);
    check("alu_wb_en", wb_en, 1'b1);
    idle(1);
    check("alu_single_pulse", wb_en, 1'b0);

    // Load bypass into an empty FIFO
    expect_wb(4'd5, 32'hAA);
    cyc(1'b0, 4'h0, 32'h0, 1'b1, 4'd5, 32'hAA);
    check("bypass_q_count", q_count, 3'd0);
    idle(2);
    check("drain_bypass", exp_q.size(), 0);

    // Starvation bound with two queued loads
    expect_wb(4'd1, 32'd100);
    cyc(1'b1, 4'd1, 32'd100, 1'b1, 4'd8, 32'h800);
    expect_wb(4'd2, 32'd101);
    cyc(1'b1, 4'd2, 32'd101, 1'b1, 4'd9, 32'h900);
    check("starve_q2", q_count, 3'd2);
    expect_wb(4'd3, 32'd102);
    cyc(1'b1, 4'd3, 32'd102, 1'b0, 4'h0, 32'h0);
    check("starve_rdy_2", alu_ready, 1'b1);
    expect_wb(4'd4, 32'd103);
    cyc(1'b1, 4'd4, 32'd103, 1'b0, 4'h0, 32'h0);
    check("starve_rdy_drop1", alu_ready, 1'b0);
    expect_wb(4'd8, 32'h800);
    cyc(1'b1, 4'd5, 32'd104, 1'b0, 4'h0, 32'h0);
    check("starve_rdy_back", alu_ready, 1'b1);
    check("starve_q1", q_count, 3'd1);
    expect_wb(4'd5, 32'd104);
    cyc(1'b1, 4'd5, 32'd104, 1'b0, 4'h0, 32'h0);
    expect_wb(4'd6, 32'd105);
    cyc(1'b1, 4'd6, 32'd105, 1'b0, 4'h0, 32'h0);
    expect_wb(4'd7, 32'd106);
    cyc(1'b1, 4'd7, 32'd106, 1'b0, 4'h0, 32'h0);
    check("starve_rdy_drop2", alu_ready, 1'b0);
    expect_wb(4'd9, 32'h900);
    cyc(1'b1, 4'd8, 32'd107, 1'b0, 4'h0, 32'h0);
    check("starve_q0", q_count, 3'd0);
    expect_wb(4'd8, 32'd107);
    cyc(1'b1, 4'd8, 32'd107, 1'b0, 4'h0, 32'h0);
    idle(2);
    check("drain_starve", exp_q.size(), 0);

    // WAW squash of a queued load
    expect_wb(4'd1, 32'h50);
    cyc(1'b1, 4'd1, 32'h50, 1'b1, 4'd7, 32'h11);
    check("waw_q1", q_count, 3'd1);
    expect_wb(4'd7, 32'h22);
    cyc(1'b1, 4'd7, 32'h22, 1'b0, 4'h0, 32'h0);
    check("waw_sq_holds_slot", q_count, 3'd1);
    idle(1);
    check("waw_pop_no_wb", wb_en, 1'b0);
    check("waw_pop_q0", q_count, 3'd0);

    // Same-cycle squash of a load accepted with the ALU write
    expect_wb(4'd9, 32'h33);
    cyc(1'b1, 4'd9, 32'h33, 1'b1, 4'd9, 32'h44);
    check("samecyc_q1", q_count, 3'd1);
    idle(1);
    check("samecyc_pop_no_wb", wb_en, 1'b0);
    idle(2);
    check("drain_waw", exp_q.size(), 0);

    // Fill under continuous ALU, then drain in order
    for (int i = 0; i < 4; i++) begin
      expect_wb(4'(i + 1), 32'h100 + 32'(i));
      cyc(1'b1, 4'(i + 1), 32'h100 + 32'(i), 1'b1, 4'(10 + i), 32'hA00 + 32'(i));
    end
    check("full_q4", q_count, 3'd4);
    check("full_mem_ready", mem_ready, 1'b0);
    for (int i = 0; i < 4; i++) expect_wb(4'(10 + i), 32'hA00 + 32'(i));
    idle(1);
    check("pop1_mem_ready", mem_ready, 1'b1);
    check("pop1_q3", q_count, 3'd3);
    idle(4);
    check("drain_fill", exp_q.size(), 0);

    // Bad destination: accepted and dropped
    cyc(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'hDEAD);
    check("bad_mem_pulse", bad_dest, 1'b1);
    check("bad_mem_no_wb", wb_en, 1'b0);
    check("bad_mem_q0", q_count, 3'd0);
    idle(1);
    check("bad_pulse_end", bad_dest, 1'b0);
    cyc(1'b1, 4'hF, 32'hBEEF, 1'b0, 4'h0, 32'h0);
    check("bad_alu_pulse", bad_dest, 1'b1);
    check("bad_alu_no_wb", wb_en, 1'b0);
    idle(1);

    // Asynchronous reset mid-burst
    expect_wb(4'd1, 32'h71);
    cyc(1'b1, 4'd1, 32'h71, 1'b1, 4'd10, 32'hA0);
    cyc(1'b1, 4'd2, 32'h72, 1'b1, 4'd11, 32'hA1);
    check("burst_wb_en", wb_en, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_wb_en", wb_en, 1'b0);
    check("arst_wb_dest", wb_dest, 4'h0);
    check("arst_wb_data", wb_data, 32'h0);
    check("arst_q_count", q_count, 3'd0);
    check("arst_bad_dest", bad_dest, 1'b0);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    check("post_rst_no_wb", wb_en, 1'b0);
    check("post_rst_q0", q_count, 3'd0);
    check("drain_final", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
